// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 raster constants, FSM states, counter width helper
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;
    localparam int DEF_LOCK_SETTLE = 16;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN
    } state_e;

    // Counter width wide enough for the larger of the two raster totals.
    function automatic int calc_cw(input int h_total, input int v_total);
        int m;
        m = (h_total > v_total) ? h_total : v_total;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchroniser, async active-low reset to 0
// Ports: clk_i destination clock, rst_ni async reset, d_i asynchronous input, q_o synchronised output
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parameterised raster timing generator gated by PLL lock
// Ports: clk pixel clock, rst_n async reset, pll_locked async lock input,
//        hsync/vsync sync levels, de data enable, x/y pixel coordinates,
//        sof start-of-frame pulse, eol end-of-active-line pulse, running in RUN
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   LOCK_SETTLE = DEF_LOCK_SETTLE,
    localparam int  CW          = calc_cw(H_ACTIVE + H_FP + H_SYNC + H_BP,
                                          V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pll_locked,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          sof,
    output logic          eol,
    output logic          running
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int SW       = $clog2(LOCK_SETTLE + 1);

    localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE - 1);

    logic          lk_s;
    state_e        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;

    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          sof_q, sof_d;
    logic          eol_q, eol_d;
    logic          running_q, running_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;

    sync_2ff u_lock_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (pll_locked),
        .q_o    (lk_s)
    );

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        h_d      = h_q;
        v_d      = v_q;
        unique case (state_q)
            WAIT_LOCK: begin
                h_d      = '0;
                v_d      = '0;
                settle_d = '0;
                if (lk_s) begin
                    if (LOCK_SETTLE == 1) begin
                        state_d = RUN;
                    end else begin
                        state_d  = SETTLE;
                        settle_d = SW'(1);
                    end
                end
            end
            SETTLE: begin
                if (!lk_s) begin
                    state_d  = WAIT_LOCK;
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    // The count reaches LOCK_SETTLE on this edge.
                    state_d = RUN;
                    h_d     = '0;
                    v_d     = '0;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            RUN: begin
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                    h_d     = '0;
                    v_d     = '0;
                end else if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
                end else begin
                    h_d = h_q + CW'(1);
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                h_d     = '0;
                v_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_LOCK;
            settle_q <= '0;
            h_q      <= '0;
            v_q      <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            h_q      <= h_d;
            v_q      <= v_d;
        end
    end

    // Outputs are gated by lk_s as well as RUN so a lost lock idles the
    // outputs on the same edge the FSM leaves RUN, without a stretched sync.
    logic run_ok;
    logic h_act, v_act, hs_win, vs_win;

    assign run_ok = (state_q == RUN) && lk_s;
    assign h_act  = int'(h_q) < H_ACTIVE;
    assign v_act  = int'(v_q) < V_ACTIVE;
    assign hs_win = (int'(h_q) >= HS_START) && (int'(h_q) < HS_END);
    assign vs_win = (int'(v_q) >= VS_START) && (int'(v_q) < VS_END);

    always_comb begin
        hsync_d   = ~SYNC_POL;
        vsync_d   = ~SYNC_POL;
        de_d      = 1'b0;
        sof_d     = 1'b0;
        eol_d     = 1'b0;
        running_d = 1'b0;
        x_d       = '0;
        y_d       = '0;
        if (run_ok) begin
            running_d = 1'b1;
            x_d       = h_q;
            y_d       = v_q;
            de_d      = h_act && v_act;
            sof_d     = (h_q == '0) && (v_q == '0);
            eol_d     = (int'(h_q) == H_ACTIVE - 1) && v_act;
            if (hs_win) hsync_d = SYNC_POL;
            if (vs_win) vsync_d = SYNC_POL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q   <= ~SYNC_POL;
            vsync_q   <= ~SYNC_POL;
            de_q      <= 1'b0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            running_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            de_q      <= de_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
            running_q <= running_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign de      = de_q;
    assign sof     = sof_q;
    assign eol     = eol_q;
    assign running = running_q;
    assign x       = x_q;
    assign y       = y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen on a reduced raster
module tb_vga_timing_gen;

    // Reduced raster: H 20/4/6/10 = 40, V 10/3/2/5 = 20, frame 800 cycles.
    localparam int HA = 20, HF = 4, HS = 6, HB = 10;
    localparam int VA = 10, VF = 3, VS = 2, VB = 5;
    localparam int LS = 16;
    localparam int SOF_LAT = 19;
    localparam int IDLE_WORD = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       hsync, vsync, de, sof, eol, running;
    logic [5:0] x, y;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE    (HA),
        .H_FP        (HF),
        .H_SYNC      (HS),
        .H_BP        (HB),
        .V_ACTIVE    (VA),
        .V_FP        (VF),
        .V_SYNC      (VS),
        .V_BP        (VB),
        .SYNC_POL    (1'b0),
        .LOCK_SETTLE (LS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .x          (x),
        .y          (y),
        .sof        (sof),
        .eol        (eol),
        .running    (running)
    );

    typedef struct {
        int   cyc;
        int   ex;
        int   ey;
        logic ede;
        logic ehs;
        logic evs;
        logic esof;
        logic eeol;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int idle_word();
        return 32'({14'd0, x, y, running, de, sof, eol, hsync, vsync});
    endfunction

    task automatic wait_sof(output int n);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (sof) break;
        end
    endtask

    task automatic wait_xy(input int wx, input int wy, output bit found);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (int'(x) == wx && int'(y) == wy) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int  n;
        int  errs;
        int  idx;
        int  c_de, c_hs, c_vs, c_eol, c_sof, c_de_blank;
        bit  found;

        //            cyc   x   y  de hs vs sof eol
        tbl.push_back('{  0,  0,  0, 1, 1, 1, 1, 0});
        tbl.push_back('{ 19, 19,  0, 1, 1, 1, 0, 1});
        tbl.push_back('{ 20, 20,  0, 0, 1, 1, 0, 0});
        tbl.push_back('{ 23, 23,  0, 0, 1, 1, 0, 0});
        tbl.push_back('{ 24, 24,  0, 0, 0, 1, 0, 0});
        tbl.push_back('{ 29, 29,  0, 0, 0, 1, 0, 0});
        tbl.push_back('{ 30, 30,  0, 0, 1, 1, 0, 0});
        tbl.push_back('{ 39, 39,  0, 0, 1, 1, 0, 0});
        tbl.push_back('{ 40,  0,  1, 1, 1, 1, 0, 0});
        tbl.push_back('{379, 19,  9, 1, 1, 1, 0, 1});
        tbl.push_back('{380, 20,  9, 0, 1, 1, 0, 0});
        tbl.push_back('{400,  0, 10, 0, 1, 1, 0, 0});
        tbl.push_back('{419, 19, 10, 0, 1, 1, 0, 0});
        tbl.push_back('{519, 39, 12, 0, 1, 1, 0, 0});
        tbl.push_back('{520,  0, 13, 0, 1, 0, 0, 0});
        tbl.push_back('{544, 24, 13, 0, 0, 0, 0, 0});
        tbl.push_back('{599, 39, 14, 0, 1, 0, 0, 0});
        tbl.push_back('{600,  0, 15, 0, 1, 1, 0, 0});
        tbl.push_back('{799, 39, 19, 0, 1, 1, 0, 0});
        tbl.push_back('{800,  0,  0, 1, 1, 1, 1, 0});

        // Reset state and idle while unlocked.
        repeat (3) @(negedge clk);
        check("reset_idle", idle_word(), IDLE_WORD);
        rst_n = 1'b1;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (idle_word() != IDLE_WORD) errs++;
        end
        check("unlocked_idle_cycles_bad", errs, 0);

        // Lock-to-sof latency.
        pll_locked = 1'b1;
        wait_sof(n);
        check("lock_to_sof", n, SOF_LAT);
        check("sof_x", int'(x), 0);
        check("sof_y", int'(y), 0);
        check("sof_de", int'(de), 1);
        check("sof_running", int'(running), 1);

        // One full frame against the vector table plus per-frame counts.
        idx = 0;
        c_de = 0; c_hs = 0; c_vs = 0; c_eol = 0; c_sof = 0; c_de_blank = 0;
        for (int k = 0; k <= 800; k++) begin
            if (k > 0) @(negedge clk);
            if (idx < tbl.size() && tbl[idx].cyc == k) begin
                check($sformatf("vec%0d_x", k), int'(x), tbl[idx].ex);
                check($sformatf("vec%0d_y", k), int'(y), tbl[idx].ey);
                check($sformatf("vec%0d_flags", k), int'({de, hsync, vsync, sof, eol}),
                      int'({tbl[idx].ede, tbl[idx].ehs, tbl[idx].evs, tbl[idx].esof, tbl[idx].eeol}));
                idx++;
            end
            if (k < 800) begin
                if (de) c_de++;
                if (!hsync) c_hs++;
                if (!vsync) c_vs++;
                if (eol) c_eol++;
                if (sof) c_sof++;
                if (de && int'(y) >= VA) c_de_blank++;
            end
        end
        check("frame_de_count", c_de, HA * VA);
        check("frame_hsync_low", c_hs, HS * 20);
        check("frame_vsync_low", c_vs, VS * 40);
        check("frame_eol_count", c_eol, VA);
        check("frame_sof_count", c_sof, 1);
        check("frame_de_in_vblank", c_de_blank, 0);

        // Lock loss mid-frame at (7,5).
        wait_xy(7, 5, found);
        check("reach_x7_y5", int'(found), 1);
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        check("drop_still_running", int'(running), 1);
        @(negedge clk);
        check("drop_idle", idle_word(), IDLE_WORD);
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (idle_word() != IDLE_WORD) errs++;
        end
        check("drop_hold_idle_bad", errs, 0);
        pll_locked = 1'b1;
        wait_sof(n);
        check("relock_to_sof", n, SOF_LAT);
        check("relock_xy", int'({x, y}), 0);

        // Lock glitch during SETTLE restarts the settle count.
        pll_locked = 1'b0;
        repeat (5) @(negedge clk);
        pll_locked = 1'b1;
        c_sof = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sof || running) c_sof++;
        end
        check("glitch_no_early_run", c_sof, 0);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        wait_sof(n);
        check("glitch_to_sof", n, SOF_LAT);

        // Asynchronous reset mid-line while hsync is asserted.
        wait_xy(26, 0, found);
        check("reach_x26", int'(found), 1);
        check("pre_reset_hsync", int'(hsync), 0);
        rst_n = 1'b0;
        #1;
        check("async_reset_idle", idle_word(), IDLE_WORD);
        @(negedge clk);
        check("reset_held_idle", idle_word(), IDLE_WORD);
        rst_n = 1'b1;
        wait_sof(n);
        check("reset_release_to_sof", n, SOF_LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
